// File: rtl/sc64.sv
// Shared SC64 mailbox definitions: version constant, N64 halfword map and SCR bit positions.
package sc64;

    localparam logic [31:0] SC64_VER = 32'h5343_7632;

    localparam int unsigned SCR_CPU_READY_BIT   = 31;
    localparam int unsigned SCR_CPU_BUSY_BIT    = 30;
    localparam int unsigned SCR_USB_WAITING_BIT = 29;
    localparam int unsigned SCR_CMD_ERROR_BIT   = 28;
    localparam int unsigned SCR_TIMEOUT_ERR_BIT = 27;

    typedef enum logic [3:0] {
        REG_SCR_H    = 4'd0,
        REG_SCR_L    = 4'd1,
        REG_DATA_0_H = 4'd2,
        REG_DATA_0_L = 4'd3,
        REG_DATA_1_H = 4'd4,
        REG_DATA_1_L = 4'd5,
        REG_CMD_H    = 4'd6,
        REG_CMD_L    = 4'd7,
        REG_VER_H    = 4'd8,
        REG_VER_L    = 4'd9
    } e_n64_cfg_reg;

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_WAIT = 1'b1
    } e_pend_state;

endpackage

// File: rtl/n64_cfg_pending.sv
// Tracks a locally issued command until the CPU picks it up (cpu_busy) or it times out.
module n64_cfg_pending
    import sc64::*;
#(
    parameter int unsigned PENDING_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic issue,
    input  logic cpu_busy,
    output logic pending,
    output logic timeout_err
);

    localparam int unsigned      CNT_W    = $clog2(PENDING_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PENDING_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    e_pend_state      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        timeout_d = timeout_q;
        if (issue) begin
            state_d   = PEND_WAIT;
            cnt_d     = '0;
            pending_d = 1'b1;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                PEND_WAIT: begin
                    if (cpu_busy) begin
                        state_d   = PEND_IDLE;
                        pending_d = 1'b0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d   = PEND_IDLE;
                        pending_d = 1'b0;
                        timeout_d = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PEND_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
        end
    end

    assign pending     = pending_q;
    assign timeout_err = timeout_q;

endmodule

// File: rtl/n64_cfg.sv
// N64-side end of the config/command mailbox: PI halfword register map, coherent
// 32-bit reads via an H-half snapshot, command issue and CPU data write-back.
module n64_cfg
    import sc64::*;
#(
    parameter int unsigned PENDING_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_request,
    input  logic        bus_write,
    input  logic [4:0]  bus_address,
    input  logic [15:0] bus_wdata,
    output logic        bus_ack,
    output logic [15:0] bus_rdata,
    input  logic        cpu_ready,
    input  logic        cpu_busy,
    input  logic        usb_waiting,
    input  logic        cmd_error,
    input  logic [31:0] cfg_wdata,
    input  logic [1:0]  cfg_data_write,
    output logic [7:0]  cmd,
    output logic        cmd_request,
    output logic [31:0] data_0,
    output logic [31:0] data_1
);

    logic        ack_q, ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        cmd_request_q, cmd_request_d;
    logic [31:0] data0_q, data0_d, data1_q, data1_d;
    logic [15:0] shadow_q, shadow_d;
    logic        snap_valid_q, snap_valid_d;
    logic [2:0]  snap_word_q, snap_word_d;

    logic         pending, timeout_err;
    logic         busy_eff_c, issue_c, is_high_c, addr_unused;
    logic [2:0]   word_idx_c;
    logic [31:0]  scr_c, live_word_c;
    e_n64_cfg_reg hw_idx_c;

    assign busy_eff_c  = cpu_busy | pending;
    assign hw_idx_c    = e_n64_cfg_reg'(bus_address[4:1]);
    assign word_idx_c  = bus_address[4:2];
    assign is_high_c   = ~bus_address[1];
    assign addr_unused = bus_address[0];

    n64_cfg_pending #(
        .PENDING_TIMEOUT(PENDING_TIMEOUT)
    ) u_pending (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue      (issue_c),
        .cpu_busy   (cpu_busy),
        .pending    (pending),
        .timeout_err(timeout_err)
    );

    // Live 32-bit view of the register pair addressed by the request
    always_comb begin
        scr_c                      = '0;
        scr_c[SCR_CPU_READY_BIT]   = cpu_ready;
        scr_c[SCR_CPU_BUSY_BIT]    = busy_eff_c;
        scr_c[SCR_USB_WAITING_BIT] = usb_waiting;
        scr_c[SCR_CMD_ERROR_BIT]   = cmd_error;
        scr_c[SCR_TIMEOUT_ERR_BIT] = timeout_err;
        case (word_idx_c)
            3'd0:    live_word_c = scr_c;
            3'd1:    live_word_c = data0_q;
            3'd2:    live_word_c = data1_q;
            3'd3:    live_word_c = {24'd0, cmd_q};
            3'd4:    live_word_c = SC64_VER;
            default: live_word_c = '0;
        endcase
    end

    always_comb begin
        ack_d        = bus_request;
        rdata_d      = '0;
        cmd_d        = cmd_q;
        data0_d      = data0_q;
        data1_d      = data1_q;
        shadow_d     = shadow_q;
        snap_valid_d = snap_valid_q;
        snap_word_d  = snap_word_q;
        issue_c      = 1'b0;
        if (bus_request) begin
            snap_valid_d = 1'b0;
            if (!bus_write) begin
                if (is_high_c) begin
                    rdata_d      = live_word_c[31:16];
                    shadow_d     = live_word_c[15:0];
                    snap_valid_d = 1'b1;
                    snap_word_d  = word_idx_c;
                end else if (snap_valid_q && (snap_word_q == word_idx_c)) begin
                    rdata_d = shadow_q;
                end else begin
                    rdata_d = live_word_c[15:0];
                end
            end else if (!busy_eff_c) begin
                case (hw_idx_c)
                    REG_DATA_0_H: data0_d[31:16] = bus_wdata;
                    REG_DATA_0_L: data0_d[15:0]  = bus_wdata;
                    REG_DATA_1_H: data1_d[31:16] = bus_wdata;
                    REG_DATA_1_L: data1_d[15:0]  = bus_wdata;
                    REG_CMD_L: begin
                        cmd_d   = bus_wdata[7:0];
                        issue_c = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        // CPU writes take the whole word over any same-cycle N64 halfword write
        if (cfg_data_write[0]) data0_d = cfg_wdata;
        if (cfg_data_write[1]) data1_d = cfg_wdata;
        cmd_request_d = issue_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q         <= 1'b0;
            rdata_q       <= '0;
            cmd_q         <= '0;
            cmd_request_q <= 1'b0;
            data0_q       <= '0;
            data1_q       <= '0;
            shadow_q      <= '0;
            snap_valid_q  <= 1'b0;
            snap_word_q   <= '0;
        end else begin
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            cmd_q         <= cmd_d;
            cmd_request_q <= cmd_request_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            shadow_q      <= shadow_d;
            snap_valid_q  <= snap_valid_d;
            snap_word_q   <= snap_word_d;
        end
    end

    assign bus_ack     = ack_q;
    assign bus_rdata   = rdata_q;
    assign cmd         = cmd_q;
    assign cmd_request = cmd_request_q;
    assign data_0      = data0_q;
    assign data_1      = data1_q;

endmodule

// File: tb/tb_n64_cfg.sv
// Directed bench for n64_cfg: register map, command issue, pending/timeout, snapshots, reset.
module tb_n64_cfg;

    localparam logic [4:0] A_SCR_H = 5'd0;
    localparam logic [4:0] A_SCR_L = 5'd2;
    localparam logic [4:0] A_D0_H  = 5'd4;
    localparam logic [4:0] A_D0_L  = 5'd6;
    localparam logic [4:0] A_D1_H  = 5'd8;
    localparam logic [4:0] A_D1_L  = 5'd10;
    localparam logic [4:0] A_CMD_L = 5'd14;
    localparam logic [4:0] A_VER_H = 5'd16;
    localparam logic [4:0] A_VER_L = 5'd18;

    logic        clk, reset_n;
    logic        bus_request, bus_write;
    logic [4:0]  bus_address;
    logic [15:0] bus_wdata, bus_rdata;
    logic        bus_ack;
    logic        cpu_ready, cpu_busy, usb_waiting, cmd_error;
    logic [31:0] cfg_wdata;
    logic [1:0]  cfg_data_write;
    logic [7:0]  cmd;
    logic        cmd_request;
    logic [31:0] data_0, data_1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [15:0] rd;
    logic [31:0] ver;

    n64_cfg #(.PENDING_TIMEOUT(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus_request   (bus_request),
        .bus_write     (bus_write),
        .bus_address   (bus_address),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .cpu_ready     (cpu_ready),
        .cpu_busy      (cpu_busy),
        .usb_waiting   (usb_waiting),
        .cmd_error     (cmd_error),
        .cfg_wdata     (cfg_wdata),
        .cfg_data_write(cfg_data_write),
        .cmd           (cmd),
        .cmd_request   (cmd_request),
        .data_0        (data_0),
        .data_1        (data_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PI access; returns just after the edge where ack/rdata are presented
    task automatic bus_op(input logic wr, input logic [4:0] addr, input logic [15:0] wd,
                          output logic [15:0] rdv);
        bus_request = 1'b1;
        bus_write   = wr;
        bus_address = addr;
        bus_wdata   = wd;
        tick();
        bus_request = 1'b0;
        bus_write   = 1'b0;
        rdv         = bus_rdata;
        check("ack", 32'(bus_ack), 32'd1);
    endtask

    task automatic cpu_write(input logic [1:0] sel, input logic [31:0] wd);
        cfg_wdata      = wd;
        cfg_data_write = sel;
        tick();
        cfg_data_write = 2'b00;
    endtask

    initial begin
        ver            = sc64::SC64_VER;
        reset_n        = 1'b0;
        bus_request    = 1'b0;
        bus_write      = 1'b0;
        bus_address    = '0;
        bus_wdata      = '0;
        cpu_ready      = 1'b0;
        cpu_busy       = 1'b0;
        usb_waiting    = 1'b0;
        cmd_error      = 1'b0;
        cfg_wdata      = '0;
        cfg_data_write = 2'b00;
        repeat (2) tick();
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_rdata", 32'(bus_rdata), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_req", 32'(cmd_request), 32'd0);
        check("rst_data0", data_0, 32'd0);
        check("rst_data1", data_1, 32'd0);
        reset_n = 1'b1;
        tick();

        // Status and version reads
        cpu_ready = 1'b1;
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_h_ready", 32'(rd), 32'h8000);
        tick();
        check("ack_drops", 32'(bus_ack), 32'd0);
        check("rdata_idle", 32'(bus_rdata), 32'd0);
        bus_op(1'b0, A_SCR_L, 16'h0, rd); check("scr_l", 32'(rd), 32'h0000);
        bus_op(1'b0, A_VER_H, 16'h0, rd); check("ver_h", 32'(rd), 32'(ver[31:16]));
        bus_op(1'b0, A_VER_L, 16'h0, rd); check("ver_l", 32'(rd), 32'(ver[15:0]));

        // Data writes and command issue
        bus_op(1'b1, A_D0_H, 16'h1234, rd);
        bus_op(1'b1, A_D0_L, 16'h5678, rd);
        check("data0_wr", data_0, 32'h1234_5678);
        bus_op(1'b1, A_CMD_L, 16'h00AB, rd);
        check("cmd_req_pulse", 32'(cmd_request), 32'd1);
        check("cmd_ab", 32'(cmd), 32'h0000_00AB);
        tick();
        check("cmd_req_single", 32'(cmd_request), 32'd0);
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_pending", 32'(rd), 32'hC000);
        bus_op(1'b0, A_CMD_L, 16'h0, rd); check("cmd_read", 32'(rd), 32'h00AB);
        cpu_busy = 1'b1;
        tick();
        // Writes while busy are acked but dropped
        bus_op(1'b1, A_D1_L, 16'hFFFF, rd);
        bus_op(1'b1, A_CMD_L, 16'h0011, rd);
        check("busy_no_req", 32'(cmd_request), 32'd0);
        check("busy_data1", data_1, 32'd0);
        check("busy_cmd", 32'(cmd), 32'h0000_00AB);
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_cpu_busy", 32'(rd), 32'hC000);
        cpu_busy = 1'b0;
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_pend_clr", 32'(rd), 32'h8000);

        // Timeout boundary: still pending on the 16th WAIT cycle, timed out after
        cpu_ready = 1'b0;
        bus_op(1'b1, A_CMD_L, 16'h0022, rd);
        check("cmd_req_22", 32'(cmd_request), 32'd1);
        repeat (15) tick();
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_last_wait", 32'(rd), 32'h4000);
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_timeout", 32'(rd), 32'h0800);
        repeat (5) tick();
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_timeout_sticky", 32'(rd), 32'h0800);
        bus_op(1'b1, A_CMD_L, 16'h0033, rd);
        check("cmd_req_33", 32'(cmd_request), 32'd1);
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_to_cleared", 32'(rd), 32'h4000);
        cpu_busy = 1'b1;
        tick();
        cpu_busy = 1'b0;
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("scr_all_clear", 32'(rd), 32'h0000);
        cpu_ready = 1'b1;

        // Coherent reads via snapshot
        cpu_write(2'b10, 32'h1111_2222);
        check("cpu_data1", data_1, 32'h1111_2222);
        bus_op(1'b0, A_D1_H, 16'h0, rd); check("snap_h", 32'(rd), 32'h1111);
        cpu_write(2'b10, 32'hCAFE_BABE);
        bus_op(1'b0, A_D1_L, 16'h0, rd); check("snap_l_old", 32'(rd), 32'h2222);
        bus_op(1'b0, A_D1_L, 16'h0, rd); check("snap_l_live", 32'(rd), 32'hBABE);
        bus_op(1'b0, A_D1_H, 16'h0, rd); check("snap_h2", 32'(rd), 32'hCAFE);
        bus_op(1'b0, A_SCR_L, 16'h0, rd);
        cpu_write(2'b10, 32'h0102_0304);
        bus_op(1'b0, A_D1_L, 16'h0, rd); check("snap_broken", 32'(rd), 32'h0304);

        // CPU write beats a same-cycle N64 halfword write
        cfg_wdata      = 32'hDEAD_BEEF;
        cfg_data_write = 2'b01;
        bus_op(1'b1, A_D0_L, 16'h0000, rd);
        cfg_data_write = 2'b00;
        check("cpu_wins", data_0, 32'hDEAD_BEEF);

        // cpu_busy rising with an issue write: write dropped
        cpu_busy = 1'b1;
        bus_op(1'b1, A_CMD_L, 16'h0044, rd);
        check("race_no_req", 32'(cmd_request), 32'd0);
        check("race_cmd", 32'(cmd), 32'h0000_0033);
        cpu_busy = 1'b0;
        tick();

        // Reset in the middle of WAIT
        bus_op(1'b1, A_CMD_L, 16'h0055, rd);
        check("cmd_req_55", 32'(cmd_request), 32'd1);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(cmd_request), 32'd0);
        check("mid_rst_cmd", 32'(cmd), 32'd0);
        check("mid_rst_data0", data_0, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_req", 32'(cmd_request), 32'd0);
        end
        bus_op(1'b0, A_SCR_H, 16'h0, rd); check("post_rst_scr", 32'(rd), 32'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
